// File: rtl/mcse_bus_arb_pkg.sv
// ============================================================================
// Module      : mcse_bus_arb_pkg
// Description : Shared state encoding and default sizes for the MCSE bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mcse_bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ        = 2;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_PAYLOAD_BITS   = 256;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

`default_nettype wire

// File: rtl/mcse_rr_picker.sv
// ============================================================================
// Module      : mcse_rr_picker
// Description : Combinational round-robin pick: first request above i_ptr, wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcse_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    logic [IDX_W-1:0] w_cand;

    // Walk from the farthest candidate down to ptr+1 so the nearest hit wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        o_grant = '0;
        w_cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
        if (o_valid) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mcse_bus_arbiter.sv
// ============================================================================
// Module      : mcse_bus_arbiter
// Description : Round-robin sharing of the MCSE bus-requester channel, one
//               transaction in flight. Optional watchdog: MCSE_BUS_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcse_bus_arbiter
    import mcse_bus_arb_pkg::*;
#(
    parameter int NUM_REQ            = DEF_NUM_REQ,
    parameter int pAHB_ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int pPAYLOAD_SIZE_BITS = DEF_PAYLOAD_BITS,
    parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req_go,
    input  logic [NUM_REQ*pAHB_ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*pPAYLOAD_SIZE_BITS-1:0] req_write,
    input  logic [NUM_REQ-1:0]                    req_rw,
    output logic [NUM_REQ-1:0]                    req_done,
    output logic                                  req_err,
    output logic [pPAYLOAD_SIZE_BITS-1:0]         req_rdata,
    output logic                                  bus_go,
    output logic [pAHB_ADDR_WIDTH-1:0]            bus_addr,
    output logic [pPAYLOAD_SIZE_BITS-1:0]         bus_write,
    output logic                                  bus_RW,
    input  logic                                  bus_done,
    input  logic [pPAYLOAD_SIZE_BITS-1:0]         bus_rdData,
    output logic [NUM_REQ-1:0]                    arb_grant,
    output logic                                  arb_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("mcse_bus_arbiter: NUM_REQ and TIMEOUT_CYCLES must be >= 2");
    end

    arb_state_e                    r_state;
    logic [IDX_W-1:0]              r_ptr;
    logic [NUM_REQ-1:0]            r_grant;
    logic [NUM_REQ-1:0]            r_done;
    logic                          r_bus_go;
    logic [pAHB_ADDR_WIDTH-1:0]    r_bus_addr;
    logic [pPAYLOAD_SIZE_BITS-1:0] r_bus_write;
    logic                          r_bus_rw;
    logic [pPAYLOAD_SIZE_BITS-1:0] r_rdata;

    logic [NUM_REQ-1:0]            w_grant;
    logic [IDX_W-1:0]              w_idx;
    logic                          w_valid;
    logic                          w_timeout;
    logic [pAHB_ADDR_WIDTH-1:0]    w_addr_arr  [NUM_REQ];
    logic [pPAYLOAD_SIZE_BITS-1:0] w_wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = req_addr[gi*pAHB_ADDR_WIDTH +: pAHB_ADDR_WIDTH];
        assign w_wdata_arr[gi] = req_write[gi*pPAYLOAD_SIZE_BITS +: pPAYLOAD_SIZE_BITS];
    end

    mcse_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req   (req_go),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_ptr       <= IDX_W'(NUM_REQ - 1);
            r_grant     <= '0;
            r_done      <= '0;
            r_bus_go    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_write <= '0;
            r_bus_rw    <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_valid) begin
                        r_state     <= ARB_BUSY;
                        r_bus_go    <= 1'b1;
                        r_bus_addr  <= w_addr_arr[w_idx];
                        r_bus_write <= w_wdata_arr[w_idx];
                        r_bus_rw    <= req_rw[w_idx];
                        r_grant     <= w_grant;
                        r_ptr       <= w_idx;
                    end
                end
                ARB_BUSY: begin
                    // A real completion takes priority over a coincident timeout.
                    if (bus_done || w_timeout) begin
                        r_state  <= ARB_DONE;
                        r_bus_go <= 1'b0;
                        r_rdata  <= bus_done ? bus_rdData : '0;
                        r_done   <= r_grant;
                    end
                end
                ARB_DONE: begin
                    r_state <= ARB_IDLE;
                    r_grant <= '0;
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

`ifdef MCSE_BUS_ARB_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDOG_W-1:0] r_wdog;
    logic              r_err;

    assign w_timeout = (r_state == ARB_BUSY) && (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err  <= w_timeout && !bus_done;
            r_wdog <= (r_state == ARB_BUSY && !bus_done && !w_timeout) ? r_wdog + 1'b1 : '0;
        end
    end

    assign req_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign req_err   = 1'b0;
`endif

    assign req_done  = r_done;
    assign req_rdata = r_rdata;
    assign bus_go    = r_bus_go;
    assign bus_addr  = r_bus_addr;
    assign bus_write = r_bus_write;
    assign bus_RW    = r_bus_rw;
    assign arb_grant = r_grant;
    assign arb_busy  = (r_state != ARB_IDLE);

endmodule

`default_nettype wire
